dense_psum_accum: RTL and testbench
===================================

// Module: dense_psum_accum
// PURPOSE
//  Consumer end of the dense PE array's psum stream (top row, NUM_COLS lanes of psum + address).
//  - Accumulates each lane into a lane-private psum bank with read-modify-write.
//  - After the array signals done, drains the banks row by row over a valid/ready stream.
//  - The stream feeds the quantizer / AXI write-back path.
//  - Address map is fixed: psum_addr = oy*NUM_COLS + ox. Lane c carries only ox == c.
//    Bank local address = psum_addr[ADDR_PSUM-1:LOG2_COLS] (= oy).
// PARAMETERS
//  ADDR_PSUM  11  psum address width from the array
//  PSUM_BW    32  psum / accumulator width
//  NUM_COLS   32  lanes = banks
//  LOG2_COLS  5   log2(NUM_COLS)
//  BANK_DEPTH 32  entries per bank; 2**(ADDR_PSUM-LOG2_COLS) >= BANK_DEPTH
// PORTS
//  clk        in   1                  clock, rising edge
//  reset      in   1                  asynchronous, active-high
//  start      in   1                  1-cycle pulse; begins clear+accumulate job
//  out_rows   in   6                  rows to drain (IMG_H of tile), 0..BANK_DEPTH
//  psum_valid in   NUM_COLS           per-lane valid for psum_rows/psum_addrs
//  psum_rows  in   PSUM_BW*NUM_COLS   lane c at [PSUM_BW*(c+1)-1 : PSUM_BW*c], signed
//  psum_addrs in   ADDR_PSUM*NUM_COLS lane c address, same packing
//  array_done in   1                  level from PE array; rising edge ends accumulation
//  out_valid  out  1                  drain beat valid
//  out_ready  in   1                  drain beat accepted when out_valid&out_ready
//  out_data   out  PSUM_BW*NUM_COLS   one output row oy, lane c = bank c entry oy
//  out_row    out  6                  oy of current beat
//  busy       out  1                  state != IDLE
//  done       out  1                  1-cycle pulse after last drain beat accepted
//  drop_err   out  1                  sticky: psum_valid seen outside ACCUM; cleared by start
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_data, out_row, busy, done and drop_err = 0; pipeline regs = 0.
//  Bank contents are not reset.
//  FSM IDLE -> CLEAR -> ACCUM -> FLUSH -> DRAIN -> IDLE.
//  - IDLE: start -> CLEAR, clear drop_err, latch out_rows. start is ignored in any other state.
//  - CLEAR: clr_ptr 0..BANK_DEPTH-1 writes 0 into all banks in parallel; BANK_DEPTH cycles, then ACCUM.
//  - ACCUM: stage1 registers psum_valid/data/addr. Stage2, next edge: bank[c][la] <= bank[c][la] + d.
//    - Data is visible 2 edges after presentation.
//    - Back-to-back same address is safe (write completes before next read); no stall, no ready.
//    - Sum wraps modulo 2**PSUM_BW (two's complement, no saturation).
//    - Local address >= BANK_DEPTH: write dropped, drop_err set.
//    - array_done rising edge (registered detect) -> FLUSH.
//  - FLUSH: 1 cycle to retire stage2, then DRAIN with rd_ptr=0.
//    - latched out_rows == 0: skip DRAIN, pulse done, go to IDLE.
//  - DRAIN: beat oy is loaded into out_data/out_row with out_valid=1 one cycle after DRAIN entry.
//    - Held stable while !out_ready.
//    - On accept: load oy+1 the same edge (no bubble).
//    - Accept of oy==out_rows-1: out_valid=0, done=1 for 1 cycle, go to IDLE.
//  - psum_valid in CLEAR/FLUSH/DRAIN/IDLE: ignored, drop_err set.
//  - start together with any event in a busy state: start is ignored.
//  - reset mid-job: immediate IDLE; partial sums are lost (next start clears).
// CONFIGURATION
//  PSUM_RELU_EN defined: drained lanes with value < 0 are output as 0. Banks are unchanged.
//  PSUM_RELU_EN undefined: raw signed sums output.
// TESTING
//  1. start, out_rows=4; lane0 addr0 data 5 then 7 on consecutive cycles; array_done
//     -> beat oy0 lane0=12, all other lanes/rows 0; done pulse after 4th beat.
//  2. lane3 addr 3+32*2 (oy2) data 0x7FFFFFFF then 1 -> oy2 lane3 = 0x80000000 (wrap).
//  3. out_ready low 5 cycles during beat oy1 -> out_data/out_row stable; row order 0,1,2,3; no loss.
//  4. psum_valid during CLEAR -> drop_err=1, banks still 0; next start clears drop_err.
//  5. Lane0 data -9; PSUM_RELU_EN on -> 0, off -> 0xFFFFFFF7; out_rows=0 -> done 2 cycles after array_done.
//  6. reset asserted mid-DRAIN -> out_valid=0, busy=0 same cycle; new job after start reads fresh zeros.

Source files
------------

// File: rtl/dense_psum_accum.sv
// Psum accumulator for the dense PE array: per-lane bank read-modify-write, then row-wise drain.
// Optional macro PSUM_RELU_EN clamps negative drained lanes to zero (banks keep raw sums).
module dense_psum_accum #(
   parameter int ADDR_PSUM  = 11,
   parameter int PSUM_BW    = 32,
   parameter int NUM_COLS   = 32,
   parameter int LOG2_COLS  = 5,
   parameter int BANK_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [5:0]                    out_rows,
   input  logic [NUM_COLS-1:0]           psum_valid,
   input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
   input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
   input  logic                          array_done,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PSUM_BW*NUM_COLS-1:0]   out_data,
   output logic [5:0]                    out_row,
   output logic                          busy,
   output logic                          done,
   output logic                          drop_err
);

   localparam int LA_W  = ADDR_PSUM - LOG2_COLS;
   localparam int PTR_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
   localparam logic [LA_W:0]    DEPTH_LIM = (LA_W+1)'(BANK_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BANK_DEPTH-1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ACCUM = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                        state_q, state_d;
   logic [PTR_W-1:0]              clr_ptr_q, clr_ptr_d;
   logic [5:0]                    rows_q, rows_d;
   logic                          adone_q, adone_d;
   logic                          out_valid_q, out_valid_d;
   logic [PSUM_BW*NUM_COLS-1:0]   out_data_q, out_data_d;
   logic [5:0]                    out_row_q, out_row_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          drop_err_q, drop_err_d;

   logic [NUM_COLS-1:0]           s1_valid_q, s1_valid_d;
   logic [PSUM_BW-1:0]            s1_data_q [NUM_COLS];
   logic [PSUM_BW-1:0]            s1_data_d [NUM_COLS];
   logic [PTR_W-1:0]              s1_la_q   [NUM_COLS];
   logic [PTR_W-1:0]              s1_la_d   [NUM_COLS];

   logic [PSUM_BW-1:0]            lane_data_s [NUM_COLS];
   logic [LA_W-1:0]               lane_la_s   [NUM_COLS];
   logic                          acc_s;
   logic [NUM_COLS-1:0]           drop_lane_s;

   logic [PSUM_BW-1:0]            bank_q [NUM_COLS][BANK_DEPTH];
   logic [NUM_COLS-1:0]           bank_we_s;
   logic [PTR_W-1:0]              bank_wa_s [NUM_COLS];
   logic [PSUM_BW-1:0]            bank_wd_s [NUM_COLS];

   logic [PTR_W-1:0]              rd_row_s;
   logic [PSUM_BW*NUM_COLS-1:0]   rd_data_s;

   // Unpack the lane buses; the bank-local address is the oy field above the ox bits.
   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) begin
         lane_data_s[c] = psum_rows[PSUM_BW*c +: PSUM_BW];
         lane_la_s[c]   = psum_addrs[ADDR_PSUM*c + LOG2_COLS +: LA_W];
      end
   end

   // Stage 1 capture: only in-range beats during ACCUM survive, everything else is a drop.
   always_comb begin
      acc_s = (state_q == S_ACCUM);
      for (int c = 0; c < NUM_COLS; c++) begin
         if (psum_valid[c] && acc_s && ({1'b0, lane_la_s[c]} < DEPTH_LIM)) begin
            s1_valid_d[c]  = 1'b1;
            drop_lane_s[c] = 1'b0;
         end else begin
            s1_valid_d[c]  = 1'b0;
            drop_lane_s[c] = psum_valid[c];
         end
         s1_data_d[c] = lane_data_s[c];
         s1_la_d[c]   = lane_la_s[c][PTR_W-1:0];
      end
   end

   // Stage 1 pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= {NUM_COLS{1'b0}};
         for (int c = 0; c < NUM_COLS; c++) begin
            s1_data_q[c] <= {PSUM_BW{1'b0}};
            s1_la_q[c]   <= {PTR_W{1'b0}};
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         for (int c = 0; c < NUM_COLS; c++) begin
            s1_data_q[c] <= s1_data_d[c];
            s1_la_q[c]   <= s1_la_d[c];
         end
      end
   end

   // Bank write port: clear sweep in CLEAR, otherwise stage 2 read-modify-write (wrapping add).
   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) begin
         if (state_q == S_CLEAR) begin
            bank_we_s[c] = 1'b1;
            bank_wa_s[c] = clr_ptr_q;
            bank_wd_s[c] = {PSUM_BW{1'b0}};
         end else if (s1_valid_q[c]) begin
            bank_we_s[c] = 1'b1;
            bank_wa_s[c] = s1_la_q[c];
            bank_wd_s[c] = bank_q[c][s1_la_q[c]] + s1_data_q[c];
         end else begin
            bank_we_s[c] = 1'b0;
            bank_wa_s[c] = s1_la_q[c];
            bank_wd_s[c] = {PSUM_BW{1'b0}};
         end
      end
   end

   // Lane-private psum banks; contents survive reset and are cleared by each new job.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_COLS; c++) begin
         if (bank_we_s[c]) begin
            bank_q[c][bank_wa_s[c]] <= bank_wd_s[c];
         end
      end
   end

   // Drain read: row 0 on the first load, otherwise the row after the one being presented.
   always_comb begin
      if (out_valid_q) begin
         rd_row_s = PTR_W'(out_row_q) + PTR_W'(1);
      end else begin
         rd_row_s = {PTR_W{1'b0}};
      end
      for (int c = 0; c < NUM_COLS; c++) begin
`ifdef PSUM_RELU_EN
         if (bank_q[c][rd_row_s][PSUM_BW-1]) begin
            rd_data_s[PSUM_BW*c +: PSUM_BW] = {PSUM_BW{1'b0}};
         end else begin
            rd_data_s[PSUM_BW*c +: PSUM_BW] = bank_q[c][rd_row_s];
         end
`else
         rd_data_s[PSUM_BW*c +: PSUM_BW] = bank_q[c][rd_row_s];
`endif
      end
   end

   // Job FSM next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      rows_d      = rows_q;
      adone_d     = array_done;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_row_d   = out_row_q;
      done_d      = 1'b0;
      drop_err_d  = drop_err_q | (|drop_lane_s);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_CLEAR;
               clr_ptr_d  = {PTR_W{1'b0}};
               rows_d     = out_rows;
               drop_err_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (clr_ptr_q == LAST_PTR) begin
               state_d = S_ACCUM;
            end else begin
               clr_ptr_d = clr_ptr_q + PTR_W'(1);
            end
         end
         S_ACCUM: begin
            if (array_done && !adone_q) begin
               state_d = S_FLUSH;
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_FLUSH: begin
            if (rows_q == 6'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_row_d   = 6'd0;
               out_data_d  = rd_data_s;
            end else if (out_ready) begin
               if (out_row_q == rows_q - 6'd1) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  out_row_d  = out_row_q + 6'd1;
                  out_data_d = rd_data_s;
               end
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Job FSM state and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         clr_ptr_q   <= {PTR_W{1'b0}};
         rows_q      <= 6'd0;
         adone_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {(PSUM_BW*NUM_COLS){1'b0}};
         out_row_q   <= 6'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         rows_q      <= rows_d;
         adone_q     <= adone_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_row_q   <= out_row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         drop_err_q  <= drop_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_row   = out_row_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dense_psum_accum.sv
// Directed bench for dense_psum_accum: vector table for accumulation, hand sequences for corner cases.
module tb_dense_psum_accum;

   localparam int NC = 32;
   localparam int BW = 32;
   localparam int AW = 11;

   logic              clk = 1'b0;
   logic              reset, start, array_done, out_ready;
   logic [5:0]        out_rows;
   logic [NC-1:0]     psum_valid;
   logic [BW*NC-1:0]  psum_rows;
   logic [AW*NC-1:0]  psum_addrs;
   logic              out_valid, busy, done, drop_err;
   logic [BW*NC-1:0]  out_data;
   logic [5:0]        out_row;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [32][32];
   logic [31:0] cap [32][32];

   typedef struct {
      int          lane;
      int          addr;
      logic [31:0] data;
      int          exp_oy;
      logic [31:0] exp_val;
   } vec_t;

   vec_t tbl [8];

   dense_psum_accum dut (
      .clk(clk), .reset(reset), .start(start), .out_rows(out_rows),
      .psum_valid(psum_valid), .psum_rows(psum_rows), .psum_addrs(psum_addrs),
      .array_done(array_done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .busy(busy), .done(done),
      .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_out(input logic [31:0] v);
`ifdef PSUM_RELU_EN
      return v[31] ? 32'd0 : v;
`else
      return v;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int r = 0; r < 32; r++)
         for (int l = 0; l < 32; l++) begin
            mdl[r][l] = 32'd0;
            cap[r][l] = 32'hDEADBEEF;
         end
   endtask

   task automatic put(input int lane, input int addr, input logic [31:0] data);
      logic [31:0] a;
      a = addr;
      psum_valid = '0;
      psum_valid[lane] = 1'b1;
      psum_rows[BW*lane +: BW] = data;
      psum_addrs[AW*lane +: AW] = a[AW-1:0];
      tick();
      psum_valid = '0;
   endtask

   // Start a job and wait until the CLEAR sweep is over.
   task automatic start_job(input int rows);
      logic [31:0] r;
      r = rows;
      out_rows = r[5:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      repeat (33) tick();
   endtask

   task automatic run_drain(input int rows, input int stall_row, input int stall_cycles);
      int got, stalls, cyc;
      logic [BW*NC-1:0] held;
      got = 0; stalls = 0; cyc = 0;
      held = '0;
      out_ready = 1'b0;
      while (got < rows && cyc < 300) begin
         tick();
         cyc++;
         if (out_valid) begin
            if (out_row == stall_row[5:0] && stalls < stall_cycles) begin
               if (stalls > 0) begin
                  chk("stall_data_stable", {63'd0, out_data === held}, 64'd1);
                  chk("stall_row_stable", {58'd0, out_row}, stall_row);
               end
               held = out_data;
               stalls++;
               out_ready = 1'b0;
            end else begin
               chk("beat_row_order", {58'd0, out_row}, got);
               for (int l = 0; l < NC; l++) begin
                  cap[got][l] = out_data[BW*l +: BW];
                  chk($sformatf("row%0d_lane%0d", got, l), {32'd0, out_data[BW*l +: BW]},
                      {32'd0, exp_out(mdl[got][l])});
               end
               out_ready = 1'b1;
               got++;
            end
         end else begin
            out_ready = 1'b0;
         end
      end
      chk("drain_beats_seen", got, rows);
      chk("drain_stalls_seen", stalls, stall_cycles);
      tick();
      chk("done_after_last", {63'd0, done}, 64'd1);
      chk("valid_low_after_last", {63'd0, out_valid}, 64'd0);
      chk("busy_low_after_last", {63'd0, busy}, 64'd0);
      out_ready = 1'b0;
      array_done = 1'b0;
      tick();
      chk("done_one_cycle", {63'd0, done}, 64'd0);
   endtask

   initial begin
      tbl[0] = '{0,  0,   32'd5,          0, 32'd12};
      tbl[1] = '{0,  0,   32'd7,          0, 32'd12};
      tbl[2] = '{3,  67,  32'h7FFFFFFF,   2, 32'h80000000};
      tbl[3] = '{3,  67,  32'd1,          2, 32'h80000000};
      tbl[4] = '{31, 127, 32'hFFFFFFFE,   3, 32'd8};
      tbl[5] = '{31, 127, 32'd10,         3, 32'd8};
      tbl[6] = '{17, 49,  32'h12345678,   1, 32'h12345679};
      tbl[7] = '{17, 49,  32'h00000001,   1, 32'h12345679};

      reset = 1'b1; start = 1'b0; array_done = 1'b0; out_ready = 1'b0;
      out_rows = 6'd0; psum_valid = '0; psum_rows = '0; psum_addrs = '0;
      tick();
      tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_drop_err", {63'd0, drop_err}, 64'd0);
      chk("rst_out_row", {58'd0, out_row}, 64'd0);
      chk("rst_out_data_zero", {63'd0, out_data === '0}, 64'd1);
      reset = 1'b0;
      tick();

      // Job A: table-driven accumulation, wrap, back-to-back, stalled drain, ignored start.
      clear_model();
      start_job(4);
      for (int i = 0; i < 8; i++) begin
         put(tbl[i].lane, tbl[i].addr, tbl[i].data);
         mdl[tbl[i].addr / 32][tbl[i].lane] += tbl[i].data;
      end
      out_rows = 6'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      array_done = 1'b1;
      run_drain(4, 1, 5);
      for (int i = 0; i < 8; i++)
         chk($sformatf("tbl%0d_value", i), {32'd0, cap[tbl[i].exp_oy][tbl[i].lane]},
             {32'd0, exp_out(tbl[i].exp_val)});
      chk("jobA_drop_err", {63'd0, drop_err}, 64'd0);

      // Job B: psum_valid during CLEAR is dropped and flagged.
      clear_model();
      out_rows = 6'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      put(0, 0, 32'd99);
      chk("clear_drop_err", {63'd0, drop_err}, 64'd1);
      repeat (28) tick();
      array_done = 1'b1;
      run_drain(4, -1, 0);
      chk("clear_drop_sticky", {63'd0, drop_err}, 64'd1);

      // Job C: zero rows, done two cycles after array_done; start clears drop_err.
      clear_model();
      start_job(0);
      chk("start_clears_drop", {63'd0, drop_err}, 64'd0);
      put(0, 0, 32'hFFFFFFF7);
      array_done = 1'b1;
      tick();
      chk("zero_rows_done_early", {63'd0, done}, 64'd0);
      tick();
      chk("zero_rows_done", {63'd0, done}, 64'd1);
      chk("zero_rows_idle", {63'd0, busy}, 64'd0);
      array_done = 1'b0;
      tick();
      chk("zero_rows_done_pulse", {63'd0, done}, 64'd0);

      // Job D: negative sums and an out-of-range local address.
      clear_model();
      start_job(1);
      put(0, 0, 32'hFFFFFFF7);
      put(5, 5, 32'hFFFFFFFF);
      put(5, 5, 32'd4);
      chk("range_drop_clean", {63'd0, drop_err}, 64'd0);
      put(2, 1026, 32'd77);
      chk("range_drop_err", {63'd0, drop_err}, 64'd1);
      mdl[0][0] = 32'hFFFFFFF7;
      mdl[0][5] = 32'd3;
      array_done = 1'b1;
      run_drain(1, -1, 0);
`ifdef PSUM_RELU_EN
      chk("neg_lane0", {32'd0, cap[0][0]}, 64'd0);
`else
      chk("neg_lane0", {32'd0, cap[0][0]}, 64'hFFFFFFF7);
`endif
      chk("pos_lane5", {32'd0, cap[0][5]}, 64'd3);
      chk("range_lane2_zero", {32'd0, cap[0][2]}, 64'd0);

      // Job E: reset mid-drain, then a fresh job drains zeros.
      clear_model();
      start_job(2);
      put(1, 1, 32'd44);
      array_done = 1'b1;
      for (int k = 0; k < 20 && !out_valid; k++) tick();
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      chk("pre_reset_lane1", {32'd0, out_data[BW*1 +: BW]}, 64'd44);
      #2;
      reset = 1'b1;
      #1;
      chk("reset_valid_low", {63'd0, out_valid}, 64'd0);
      chk("reset_busy_low", {63'd0, busy}, 64'd0);
      #1;
      reset = 1'b0;
      array_done = 1'b0;
      tick();
      start_job(2);
      array_done = 1'b1;
      run_drain(2, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
